// File: rtl/mips_abb_pkg.sv
// Shared types and constants for the pipeline stall controller:
// hold-vector encoding, canonical stall patterns and the multi-cycle timer states.
package mips_abb_pkg;

    localparam int STAGES = 6;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    typedef logic [STAGES-1:0] stack;

    // Bit i holds pipeline register i (0=pc .. 5=wb); a stage holds when its bit is STOP.
    localparam stack STALL_NONE = 6'b000000;
    localparam stack STALL_ID   = 6'b000111;
    localparam stack STALL_EXE  = 6'b001111;
    localparam stack STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_t;

endpackage

// File: rtl/stall_ctrl_if.sv
// Stall request / hold-vector bundle between the pipeline stages and stall_ctrl.
// All signals are levels sampled on the rising clock edge; stop is valid in the same cycle as the requests.
interface stall_ctrl_if;
    import mips_abb_pkg::*;

    logic      id_stallreq;
    logic      exe_mc_req;
    logic      mem_stallreq;
    logic      flush;
    stack      stop;
    logic      exe_mc_done;
    logic      mc_busy;
    mc_state_t mc_state;

    modport master (
        output id_stallreq, exe_mc_req, mem_stallreq, flush,
        input  stop, exe_mc_done, mc_busy, mc_state
    );

    modport slave (
        input  id_stallreq, exe_mc_req, mem_stallreq, flush,
        output stop, exe_mc_done, mc_busy, mc_state
    );

endinterface

// File: rtl/stall_mc_timer.sv
// Multi-cycle op timer: counts EXE div/divu latency and signals when the result may leave EXE.
// Flush always wins and abandons the op without a done pulse.
module stall_mc_timer
    import mips_abb_pkg::*;
#(
    parameter int MC_LAT = 32
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_exe_mc_req,
    input  logic      i_mem_stallreq,
    input  logic      i_flush,
    output mc_state_t o_state,
    output logic      o_exe_mc_done
);

    localparam int CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 2);

    mc_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    mc_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= MC_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The divider runs freely, so BUSY keeps counting even while MEM stalls.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_flush) begin
            w_state_nxt = MC_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                MC_IDLE: begin
                    if (i_exe_mc_req && !i_mem_stallreq) begin
                        w_state_nxt = MC_BUSY;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
                MC_BUSY: begin
                    if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
                    else             w_state_nxt = MC_DONE;
                end
                MC_DONE: begin
                    if (!i_mem_stallreq) w_state_nxt = MC_IDLE;
                end
                default: begin
                    w_state_nxt = MC_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        o_state       = r_state;
        o_exe_mc_done = (r_state == MC_DONE) && !i_mem_stallreq && !i_flush;
    end

endmodule

// File: rtl/stall_ctrl.sv
// Central pipeline stall generator: priority-encodes flush, MEM, EXE multi-cycle and ID
// requests into the per-stage hold vector; the multi-cycle timer lives in stall_mc_timer.
module stall_ctrl
    import mips_abb_pkg::*;
#(
    parameter int MC_LAT = 32
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    stall_ctrl_if.slave bus
);

    mc_state_t w_state;
    logic      w_done;
    stack      w_stop;

    stall_mc_timer #(.MC_LAT(MC_LAT)) u_timer (
        .i_clk          (cpu_clk),
        .i_rst          (cpu_rst),
        .i_exe_mc_req   (bus.exe_mc_req),
        .i_mem_stallreq (bus.mem_stallreq),
        .i_flush        (bus.flush),
        .o_state        (w_state),
        .o_exe_mc_done  (w_done)
    );

    // In MC_DONE the EXE request no longer holds, letting the result advance this edge.
    always_comb begin
        w_stop = STALL_NONE;
        if (cpu_rst)                                  w_stop = STALL_NONE;
        else if (bus.flush)                           w_stop = STALL_NONE;
        else if (bus.mem_stallreq)                    w_stop = STALL_MEM;
        else if (bus.exe_mc_req && w_state != MC_DONE) w_stop = STALL_EXE;
        else if (bus.id_stallreq)                     w_stop = STALL_ID;
    end

    assign bus.stop        = w_stop;
    assign bus.exe_mc_done = w_done;
    assign bus.mc_busy     = (w_state != MC_IDLE);
    assign bus.mc_state    = w_state;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed-vector bench for stall_ctrl with MC_LAT=4: the driver queues the expected
// {stop, done, busy, state} per cycle and a negedge monitor pops and compares.
module tb_stall_ctrl;
    import mips_abb_pkg::*;

    localparam int LAT = 4;
    localparam int W   = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stall_ctrl_if bus ();

    stall_ctrl #(.MC_LAT(LAT)) dut (
        .cpu_clk (clk),
        .cpu_rst (rst),
        .bus     (bus)
    );

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_vec = 0;
    int           n_err = 0;

    task automatic step(input logic r, input logic id, input logic exe, input logic mem,
                        input logic fl, input logic [5:0] e_stop, input logic e_done,
                        input logic e_busy, input logic [1:0] e_st, input string tag);
        rst              = r;
        bus.id_stallreq  = id;
        bus.exe_mc_req   = exe;
        bus.mem_stallreq = mem;
        bus.flush        = fl;
        exp_q.push_back({e_stop, e_done, e_busy, e_st});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [W-1:0] e;
            logic [W-1:0] a;
            string        t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {bus.stop, bus.exe_mc_done, bus.mc_busy, bus.mc_state};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got stop=%b done=%b busy=%b st=%0d, want stop=%b done=%b busy=%b st=%0d",
                         t, a[9:4], a[3], a[2], a[1:0], e[9:4], e[3], e[2], e[1:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        bus.id_stallreq  = 1'b0;
        bus.exe_mc_req   = 1'b0;
        bus.mem_stallreq = 1'b0;
        bus.flush        = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        //    rst id exe mem fl  stop       dn bz state
        step(1, 0, 0, 0, 0, 6'b000000, 0, 0, 2'd0, "reset_idle");

        // reset mid-op with every request high
        step(0, 0, 1, 0, 0, 6'b001111, 0, 0, 2'd0, "rst_op_c0");
        step(0, 0, 1, 0, 0, 6'b001111, 0, 1, 2'd1, "rst_op_c1");
        step(0, 0, 1, 0, 0, 6'b001111, 0, 1, 2'd1, "rst_op_c2");
        step(1, 1, 1, 1, 0, 6'b000000, 0, 0, 2'd0, "rst_assert_a");
        step(1, 1, 1, 1, 0, 6'b000000, 0, 0, 2'd0, "rst_assert_b");
        step(0, 0, 0, 0, 0, 6'b000000, 0, 0, 2'd0, "rst_release_a");
        step(0, 0, 0, 0, 0, 6'b000000, 0, 0, 2'd0, "rst_release_b");

        // single-cycle load-use stall
        step(0, 1, 0, 0, 0, 6'b000111, 0, 0, 2'd0, "id_stall");
        step(0, 0, 0, 0, 0, 6'b000000, 0, 0, 2'd0, "id_release");

        // full multi-cycle op, then back-to-back restart
        step(0, 0, 1, 0, 0, 6'b001111, 0, 0, 2'd0, "mc_c0");
        step(0, 0, 1, 0, 0, 6'b001111, 0, 1, 2'd1, "mc_c1");
        step(0, 0, 1, 0, 0, 6'b001111, 0, 1, 2'd1, "mc_c2");
        step(0, 0, 1, 0, 0, 6'b001111, 0, 1, 2'd1, "mc_c3");
        step(0, 0, 1, 0, 0, 6'b000000, 1, 1, 2'd2, "mc_c4_done");
        step(0, 0, 1, 0, 0, 6'b001111, 0, 0, 2'd0, "mc_c5_restart");
        step(0, 0, 0, 0, 0, 6'b000000, 0, 1, 2'd1, "mc2_c1");
        step(0, 0, 0, 0, 0, 6'b000000, 0, 1, 2'd1, "mc2_c2");
        step(0, 0, 0, 0, 0, 6'b000000, 0, 1, 2'd1, "mc2_c3");
        step(0, 0, 0, 0, 0, 6'b000000, 1, 1, 2'd2, "mc2_done");
        step(0, 0, 0, 0, 0, 6'b000000, 0, 0, 2'd0, "mc2_idle");

        // priority: MEM over EXE over ID
        step(0, 1, 1, 1, 0, 6'b011111, 0, 0, 2'd0, "prio_all");
        step(0, 1, 1, 0, 0, 6'b001111, 0, 0, 2'd0, "prio_no_mem");
        step(0, 1, 1, 0, 1, 6'b000000, 0, 1, 2'd1, "prio_flush");
        step(0, 0, 0, 0, 0, 6'b000000, 0, 0, 2'd0, "prio_idle");

        // flush in cycle 2 of an op, no done pulse afterwards
        step(0, 0, 1, 0, 0, 6'b001111, 0, 0, 2'd0, "fl_c0");
        step(0, 0, 1, 0, 0, 6'b001111, 0, 1, 2'd1, "fl_c1");
        step(0, 0, 1, 0, 1, 6'b000000, 0, 1, 2'd1, "fl_c2");
        step(0, 0, 0, 0, 0, 6'b000000, 0, 0, 2'd0, "fl_c3");
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 0, 6'b000000, 0, 0, 2'd0, "fl_no_pulse");

        // MEM stall overlapping the end of an op
        step(0, 0, 1, 0, 0, 6'b001111, 0, 0, 2'd0, "ov_c0");
        step(0, 0, 1, 0, 0, 6'b001111, 0, 1, 2'd1, "ov_c1");
        step(0, 0, 1, 0, 0, 6'b001111, 0, 1, 2'd1, "ov_c2");
        step(0, 0, 1, 1, 0, 6'b011111, 0, 1, 2'd1, "ov_c3");
        step(0, 0, 1, 1, 0, 6'b011111, 0, 1, 2'd2, "ov_c4");
        step(0, 0, 1, 1, 0, 6'b011111, 0, 1, 2'd2, "ov_c5");
        step(0, 0, 1, 1, 0, 6'b011111, 0, 1, 2'd2, "ov_c6");
        step(0, 0, 1, 0, 0, 6'b000000, 1, 1, 2'd2, "ov_c7_done");
        step(0, 0, 0, 0, 0, 6'b000000, 0, 0, 2'd0, "ov_c8_idle");

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
